scan_reg_n: RTL and testbench

- Parametrised N-bit mux-scan register cell for the NBGen primitive library.
- Successor to the single-bit combinational primitives (bufg/notg/and_n family); the first library primitive with state.
- Supports three operations:
  - parallel capture from the functional D bus;
  - externally-driven single-step shift (se);
  - self-timed N-cycle shift sequence with busy/done handshake, so a testbench or ATPG driver can unload/load a full chain with one pulse.
- Instantiated by netlist mapping wherever a register must be scan-accessible.

---
 rtl/scan_reg_n.sv | 85 ++++++++
 tb/tb_scan_reg_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_reg_n.sv
// N-bit mux-scan register with capture, single-step shift
// and a self-timed N-shift unload/load sequencer.
module scan_reg_n #(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0,
  parameter int           CNT_W   = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         cap,
  input  logic         se,
  input  logic         si,
  input  logic         scan_start,
  output logic [N-1:0] q,
  output logic         so,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       q_q, q_d;
  logic [N-1:0]       shifted;
  logic               last_shift;

  assign shifted    = {q_q[N-2:0], si};
  assign last_shift = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        // start wins over se, se wins over cap
        if (scan_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else if (se) begin
          q_d = shifted;
        end else if (cap) begin
          q_d = d;
        end
      end
      SHIFT: begin
        q_d   = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q    = q_q;
  assign so   = q_q[N-1];
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_scan_reg_n.sv
// Randomised + directed bench for scan_reg_n against a
// countdown-based behavioural model.
module tb_scan_reg_n;

  localparam int           N   = 8;
  localparam logic [N-1:0] RST = 8'h3C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] d;
  logic         cap, se, si, scan_start;
  logic [N-1:0] q;
  logic         so, busy, done;

  int total = 0;
  int bad   = 0;

  // model: q value plus edges left until the sequencer is idle
  int unsigned q_m;
  int          left_m;

  scan_reg_n #(.N(N), .RST_VAL(RST)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .cap(cap), .se(se),
    .si(si), .scan_start(scan_start), .q(q), .so(so),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m    = RST;
    left_m = 0;
  endtask

  task automatic model_edge();
    int unsigned sh;
    sh = ((q_m << 1) | si) & ((1 << N) - 1);
    if (left_m > 0) begin
      if (left_m > 1) q_m = sh;
      left_m--;
    end else if (scan_start) begin
      left_m = N + 1;
    end else if (se) begin
      q_m = sh;
    end else if (cap) begin
      q_m = d;
    end
  endtask

  task automatic check_all();
    chk("q", q, q_m);
    chk("so", so, (q_m >> (N - 1)) & 1);
    chk("busy", busy, left_m != 0);
    chk("done", done, left_m == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    cap = 0; se = 0; si = 0; scan_start = 0;
  endtask

  logic [1:0]   si_pat_bits;
  logic [N-1:0] si_pat;
  logic [N-1:0] so_seen;
  int           done_cnt;

  initial begin
    rst_n = 1; d = '0;
    idle_in();
    model_reset();
    // reset asserted mid-cycle
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("rst_q", q, 8'h3C);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_so", so, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;

    // capture then hold
    d = 8'hA5; cap = 1;
    tick();
    chk("cap_q", q, 8'hA5);
    chk("cap_so", so, 1);
    cap = 0; d = 8'h00;
    tick();
    chk("hold_q", q, 8'hA5);

    // auto sequence
    si_pat = 8'b11001100;
    scan_start = 1;
    tick();
    scan_start = 0;
    done_cnt = 0;
    for (int k = 0; k < N; k++) begin
      si = si_pat[N-1-k];
      so_seen[N-1-k] = so;
      tick();
      done_cnt += done;
    end
    chk("seq_so", so_seen, 8'b10100101);
    chk("seq_q", q, 8'hCC);
    chk("seq_done", done, 1);
    tick();
    chk("seq_idle", busy, 0);
    chk("seq_done_n", done_cnt, 1);

    // ignored inputs during SHIFT and DONE
    d = 8'hA5; cap = 1;
    tick();
    scan_start = 1; cap = 0;
    tick();
    cap = 1; se = 1;
    for (int k = 0; k < N + 1; k++) begin
      si = (k < N) ? si_pat[N-1-k] : 1'b1;
      scan_start = 1'($urandom_range(0, 1));
      d = N'($urandom);
      tick();
    end
    chk("ign_q", q, 8'hCC);
    chk("ign_busy", busy, 0);
    idle_in();
    tick();

    // direct scan
    d = 8'h01; cap = 1;
    tick();
    cap = 0; se = 1; si = 0;
    repeat (7) tick();
    chk("dscan_q", q, 8'h80);
    chk("dscan_so", so, 1);
    cap = 1; si = 1; d = 8'h00;
    tick();
    chk("se_over_cap", q, 8'h01);
    idle_in();

    // reset mid-sequence
    scan_start = 1;
    tick();
    scan_start = 0;
    si = 1;
    repeat (4) tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_q", q, 8'h3C);
    chk("mid_rst_busy", busy, 0);
    check_all();
    @(negedge clk);
    rst_n = 1;
    done_cnt = 0;
    repeat (3) begin
      tick();
      done_cnt += done;
    end
    chk("mid_rst_nodone", done_cnt, 0);
    scan_start = 1;
    tick();
    scan_start = 0;
    for (int k = 0; k < N; k++) begin
      si = 1'(k);
      tick();
    end
    chk("post_rst_done", done, 1);
    tick();

    // random traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      d = N'($urandom);
      cap = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0);
      si = 1'($urandom_range(0, 1));
      scan_start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
